// File: rtl/oc_read_collector_if.sv
// Bus between the RF bank read path, the operand collector and execute dispatch.
// Banked read responses are packed per bank index (bank 0 = element 0).
interface oc_read_collector_if #(
  parameter int NUM_OC = 8,
  parameter int DATA_W = 256,
  parameter int TAG_W  = 6
);
  localparam int ID_W = $clog2(NUM_OC);
  localparam int NB   = 4;

  logic                           alloc_valid;
  logic [ID_W-1:0]                alloc_ocid;
  logic                           alloc_need1;
  logic                           alloc_need2;
  logic [TAG_W-1:0]               alloc_tag;
  logic [NUM_OC-1:0]              free_mask;
  logic [NB-1:0]                  rd_valid;
  logic [NB-1:0][ID_W:0]          rd_ocid;
  logic [NB-1:0][DATA_W-1:0]      rd_data;
  logic                           issue_valid;
  logic                           issue_ready;
  logic [ID_W-1:0]                issue_ocid;
  logic [TAG_W-1:0]               issue_tag;
  logic [DATA_W-1:0]              issue_src1;
  logic [DATA_W-1:0]              issue_src2;
  logic                           err;

  modport master (
    output alloc_valid, alloc_ocid, alloc_need1, alloc_need2, alloc_tag,
    output rd_valid, rd_ocid, rd_data, issue_ready,
    input  free_mask, issue_valid, issue_ocid, issue_tag, issue_src1, issue_src2, err
  );

  modport slave (
    input  alloc_valid, alloc_ocid, alloc_need1, alloc_need2, alloc_tag,
    input  rd_valid, rd_ocid, rd_data, issue_ready,
    output free_mask, issue_valid, issue_ocid, issue_tag, issue_src1, issue_src2, err
  );
endinterface

// File: rtl/oc_read_collector.sv
// Operand collector: steers RF bank read responses into entries and round-robin issues complete ones.
// Optional OC_ERR_CHK_EN adds a sticky protocol error flag (alloc to busy entry, dropped responses).
module oc_read_collector #(
  parameter int NUM_OC = 8,
  parameter int DATA_W = 256,
  parameter int TAG_W  = 6
) (
  input  logic clk,
  input  logic rst,
  oc_read_collector_if.slave oc
);
  localparam int ID_W = $clog2(NUM_OC);
  localparam int NB   = 4;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ent_st_e;

  ent_st_e             st_q   [NUM_OC];
  ent_st_e             st_d   [NUM_OC];
  logic [NUM_OC-1:0]   pend1_q, pend1_d;
  logic [NUM_OC-1:0]   pend2_q, pend2_d;
  logic [DATA_W-1:0]   op1_q  [NUM_OC];
  logic [DATA_W-1:0]   op1_d  [NUM_OC];
  logic [DATA_W-1:0]   op2_q  [NUM_OC];
  logic [DATA_W-1:0]   op2_d  [NUM_OC];
  logic [TAG_W-1:0]    tag_q  [NUM_OC];
  logic [TAG_W-1:0]    tag_d  [NUM_OC];
  logic [ID_W-1:0]     ptr_q, ptr_d;

  logic                iss_vld_q, iss_vld_d;
  logic [ID_W-1:0]     iss_ocid_q, iss_ocid_d;
  logic [TAG_W-1:0]    iss_tag_q, iss_tag_d;
  logic [DATA_W-1:0]   iss_src1_q, iss_src1_d;
  logic [DATA_W-1:0]   iss_src2_q, iss_src2_d;

  logic [ID_W-1:0]     rd_ent [NB];
  logic                rd_sel [NB];
  logic                load_en;
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;

`ifdef OC_ERR_CHK_EN
  logic                err_q, err_d;
  logic [NB-1:0]       rd_acc;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_rd_split
    assign rd_ent[b] = oc.rd_ocid[b][ID_W:1];
    assign rd_sel[b] = oc.rd_ocid[b][0];
  end

  for (genvar e = 0; e < NUM_OC; e++) begin : g_free
    assign oc.free_mask[e] = (st_q[e] == ST_FREE);
  end

  // Round-robin search over entries READY in registered state, starting at ptr_q.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      if (!pick_found && st_q[(int'(ptr_q) + i) % NUM_OC] == ST_READY) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(ptr_q) + i) % NUM_OC);
      end
    end
  end

  assign load_en = !iss_vld_q || oc.issue_ready;

  always_comb begin
    st_d       = st_q;
    pend1_d    = pend1_q;
    pend2_d    = pend2_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    tag_d      = tag_q;
    ptr_d      = ptr_q;
    iss_vld_d  = iss_vld_q;
    iss_ocid_d = iss_ocid_q;
    iss_tag_d  = iss_tag_q;
    iss_src1_d = iss_src1_q;
    iss_src2_d = iss_src2_q;
`ifdef OC_ERR_CHK_EN
    rd_acc     = '0;
`endif

    // Clearing the pend bit in the _d copy makes later banks hitting the same slot drop,
    // so the lowest bank index wins a same-cycle collision.
    for (int b = 0; b < NB; b++) begin
      if (oc.rd_valid[b] && st_q[rd_ent[b]] == ST_WAIT) begin
        if (!rd_sel[b] && pend1_d[rd_ent[b]]) begin
          pend1_d[rd_ent[b]] = 1'b0;
          op1_d[rd_ent[b]]   = oc.rd_data[b];
`ifdef OC_ERR_CHK_EN
          rd_acc[b]          = 1'b1;
`endif
        end else if (rd_sel[b] && pend2_d[rd_ent[b]]) begin
          pend2_d[rd_ent[b]] = 1'b0;
          op2_d[rd_ent[b]]   = oc.rd_data[b];
`ifdef OC_ERR_CHK_EN
          rd_acc[b]          = 1'b1;
`endif
        end
      end
    end

    for (int e = 0; e < NUM_OC; e++) begin
      if (st_q[e] == ST_WAIT && !pend1_d[e] && !pend2_d[e]) st_d[e] = ST_READY;
    end

    if (oc.alloc_valid && st_q[oc.alloc_ocid] == ST_FREE) begin
      st_d[oc.alloc_ocid]    = (oc.alloc_need1 || oc.alloc_need2) ? ST_WAIT : ST_READY;
      pend1_d[oc.alloc_ocid] = oc.alloc_need1;
      pend2_d[oc.alloc_ocid] = oc.alloc_need2;
      op1_d[oc.alloc_ocid]   = '0;
      op2_d[oc.alloc_ocid]   = '0;
      tag_d[oc.alloc_ocid]   = oc.alloc_tag;
    end

    if (load_en) begin
      iss_vld_d = pick_found;
      if (pick_found) begin
        iss_ocid_d     = pick_id;
        iss_tag_d      = tag_q[pick_id];
        iss_src1_d     = op1_q[pick_id];
        iss_src2_d     = op2_q[pick_id];
        st_d[pick_id]  = ST_FREE;
        ptr_d          = ID_W'((int'(pick_id) + 1) % NUM_OC);
      end
    end

`ifdef OC_ERR_CHK_EN
    err_d = err_q
          | (oc.alloc_valid && st_q[oc.alloc_ocid] != ST_FREE)
          | (|(oc.rd_valid & ~rd_acc));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_OC; e++) st_q[e] <= ST_FREE;
      pend1_q    <= '0;
      pend2_q    <= '0;
      ptr_q      <= '0;
      iss_vld_q  <= 1'b0;
      iss_ocid_q <= '0;
      iss_tag_q  <= '0;
      iss_src1_q <= '0;
      iss_src2_q <= '0;
    end else begin
      st_q       <= st_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      ptr_q      <= ptr_d;
      iss_vld_q  <= iss_vld_d;
      iss_ocid_q <= iss_ocid_d;
      iss_tag_q  <= iss_tag_d;
      iss_src1_q <= iss_src1_d;
      iss_src2_q <= iss_src2_d;
    end
  end

  // Entry payload is always rewritten at alloc, so it carries no reset.
  always_ff @(posedge clk) begin
    op1_q <= op1_d;
    op2_q <= op2_d;
    tag_q <= tag_d;
  end

`ifdef OC_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign oc.err = err_q;
`else
  assign oc.err = 1'b0;
`endif

  assign oc.issue_valid = iss_vld_q;
  assign oc.issue_ocid  = iss_ocid_q;
  assign oc.issue_tag   = iss_tag_q;
  assign oc.issue_src1  = iss_src1_q;
  assign oc.issue_src2  = iss_src2_q;
endmodule

// File: tb/tb_oc_read_collector.sv
// Scoreboard-driven bench for oc_read_collector; expected issues are queued as stimulus is driven.
module tb_oc_read_collector;
  localparam int NUM_OC = 8;
  localparam int DATA_W = 256;
  localparam int TAG_W  = 6;
`ifdef OC_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]        ocid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t ex;

  oc_read_collector_if #(.NUM_OC(NUM_OC), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  oc_read_collector #(.NUM_OC(NUM_OC), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .oc(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic idle_inputs();
    bus.alloc_valid = 1'b0;
    bus.alloc_ocid  = '0;
    bus.alloc_need1 = 1'b0;
    bus.alloc_need2 = 1'b0;
    bus.alloc_tag   = '0;
    bus.rd_valid    = '0;
    bus.rd_ocid     = '0;
    bus.rd_data     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.issue_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic alloc(input logic [2:0] id, input logic n1, input logic n2, input logic [TAG_W-1:0] tg);
    bus.alloc_valid = 1'b1;
    bus.alloc_ocid  = id;
    bus.alloc_need1 = n1;
    bus.alloc_need2 = n2;
    bus.alloc_tag   = tg;
  endtask

  task automatic resp(input int b, input logic [3:0] ocid, input logic [DATA_W-1:0] d);
    bus.rd_valid[b] = 1'b1;
    bus.rd_ocid[b]  = ocid;
    bus.rd_data[b]  = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.free_mask !== 8'hFF) begin failures++; $display("FAIL rst_free act=%h exp=ff", bus.free_mask); end
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL rst_valid act=%b exp=0", bus.issue_valid); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err act=%b exp=0", bus.err); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] a, b;
    a = rnd(); b = rnd();
    do_reset();
    alloc(3'd2, 1'b1, 1'b1, 6'd5);
    tick(); idle_inputs();
    checks++; if (bus.free_mask[2] !== 1'b0) begin failures++; $display("FAIL t1_busy act=%b exp=0", bus.free_mask[2]); end
    resp(1, 4'b0100, a);
    tick(); idle_inputs();
    tick(); tick();
    resp(3, 4'b0101, b);
    sb.push_back('{ocid: 3'd2, tag: 6'd5, s1: a, s2: b});
    tick(); idle_inputs();
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t1_early act=%b exp=0", bus.issue_valid); end
    tick();
    checks++; if (bus.issue_valid !== 1'b1) begin failures++; $display("FAIL t1_valid act=%b exp=1", bus.issue_valid); end
    checks++; if (bus.free_mask[2] !== 1'b1) begin failures++; $display("FAIL t1_freed act=%b exp=1", bus.free_mask[2]); end
    if (sb.size() == 0) begin checks++; failures++; $display("FAIL t1_sb_empty act=0 exp=1"); end
    else begin
      ex = sb.pop_front();
      checks++; if (bus.issue_ocid !== ex.ocid) begin failures++; $display("FAIL t1_ocid act=%0d exp=%0d", bus.issue_ocid, ex.ocid); end
      checks++; if (bus.issue_tag !== ex.tag) begin failures++; $display("FAIL t1_tag act=%0d exp=%0d", bus.issue_tag, ex.tag); end
      checks++; if (bus.issue_src1 !== ex.s1) begin failures++; $display("FAIL t1_src1 act=%h exp=%h", bus.issue_src1, ex.s1); end
      checks++; if (bus.issue_src2 !== ex.s2) begin failures++; $display("FAIL t1_src2 act=%h exp=%h", bus.issue_src2, ex.s2); end
    end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t1_drop act=%b exp=0", bus.issue_valid); end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] d[4];
    for (int i = 0; i < 4; i++) d[i] = rnd();
    do_reset();
    bus.issue_ready = 1'b1;
    alloc(3'd0, 1'b1, 1'b0, 6'd10); tick();
    alloc(3'd3, 1'b1, 1'b0, 6'd13); tick();
    alloc(3'd6, 1'b1, 1'b0, 6'd16); tick();
    alloc(3'd1, 1'b1, 1'b0, 6'd11); tick();
    idle_inputs();
    resp(0, 4'b0000, d[0]);
    resp(1, 4'b0110, d[1]);
    resp(2, 4'b1100, d[2]);
    sb.push_back('{ocid: 3'd0, tag: 6'd10, s1: d[0], s2: '0});
    sb.push_back('{ocid: 3'd3, tag: 6'd13, s1: d[1], s2: '0});
    sb.push_back('{ocid: 3'd6, tag: 6'd16, s1: d[2], s2: '0});
    sb.push_back('{ocid: 3'd1, tag: 6'd11, s1: d[3], s2: '0});
    tick(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_inputs();
      if (i == 1) resp(3, 4'b0010, d[3]);
      checks++; if (bus.issue_valid !== 1'b1) begin failures++; $display("FAIL t2_valid%0d act=%b exp=1", i, bus.issue_valid); end
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        checks++; if (bus.issue_ocid !== ex.ocid) begin failures++; $display("FAIL t2_ocid%0d act=%0d exp=%0d", i, bus.issue_ocid, ex.ocid); end
        checks++; if (bus.issue_tag !== ex.tag) begin failures++; $display("FAIL t2_tag%0d act=%0d exp=%0d", i, bus.issue_tag, ex.tag); end
        checks++; if (bus.issue_src1 !== ex.s1) begin failures++; $display("FAIL t2_src1_%0d act=%h exp=%h", i, bus.issue_src1, ex.s1); end
      end
    end
    idle_inputs();
    tick();
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t2_idle act=%b exp=0", bus.issue_valid); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    alloc(3'd4, 1'b0, 1'b0, 6'd33); tick();
    alloc(3'd5, 1'b0, 1'b0, 6'd44); tick();
    idle_inputs();
    sb.push_back('{ocid: 3'd4, tag: 6'd33, s1: '0, s2: '0});
    sb.push_back('{ocid: 3'd5, tag: 6'd44, s1: '0, s2: '0});
    ex = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.issue_valid !== 1'b1) begin failures++; $display("FAIL t3_hold_valid%0d act=%b exp=1", i, bus.issue_valid); end
      checks++; if (bus.issue_ocid !== ex.ocid || bus.issue_tag !== ex.tag) begin failures++; $display("FAIL t3_hold%0d act=%0d/%0d exp=%0d/%0d", i, bus.issue_ocid, bus.issue_tag, ex.ocid, ex.tag); end
    end
    bus.issue_ready = 1'b1;
    ex = sb.pop_front();
    tick();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_ocid !== ex.ocid || bus.issue_tag !== ex.tag) begin
      failures++; $display("FAIL t3_next act=%b/%0d/%0d exp=1/%0d/%0d", bus.issue_valid, bus.issue_ocid, bus.issue_tag, ex.ocid, ex.tag);
    end
    checks++; if (bus.issue_src1 !== ex.s1 || bus.issue_src2 !== ex.s2) begin failures++; $display("FAIL t3_zero_src act=%h exp=0", bus.issue_src1 | bus.issue_src2); end
    tick();
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t3_drop act=%b exp=0", bus.issue_valid); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_dual_land();
    logic [DATA_W-1:0] d0, d2;
    d0 = rnd(); d2 = rnd();
    do_reset();
    alloc(3'd1, 1'b1, 1'b1, 6'd21); tick(); idle_inputs();
    resp(0, 4'b0010, d0);
    resp(2, 4'b0011, d2);
    sb.push_back('{ocid: 3'd1, tag: 6'd21, s1: d0, s2: d2});
    tick(); idle_inputs();
    checks++; if (bus.issue_valid !== 1'b0 || bus.free_mask[1] !== 1'b0) begin failures++; $display("FAIL t4_ready act=%b/%b exp=0/0", bus.issue_valid, bus.free_mask[1]); end
    tick();
    ex = sb.pop_front();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_ocid !== ex.ocid) begin failures++; $display("FAIL t4_issue act=%b/%0d exp=1/%0d", bus.issue_valid, bus.issue_ocid, ex.ocid); end
    checks++; if (bus.issue_src1 !== ex.s1) begin failures++; $display("FAIL t4_src1 act=%h exp=%h", bus.issue_src1, ex.s1); end
    checks++; if (bus.issue_src2 !== ex.s2) begin failures++; $display("FAIL t4_src2 act=%h exp=%h", bus.issue_src2, ex.s2); end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] p, q;
    p = rnd(); q = rnd();
    do_reset();
    alloc(3'd7, 1'b1, 1'b0, 6'd2); tick(); idle_inputs();
    resp(3, 4'b1110, q);
    resp(1, 4'b1110, p);
    sb.push_back('{ocid: 3'd7, tag: 6'd2, s1: p, s2: '0});
    tick(); idle_inputs();
    checks++; if (bus.err !== ERR_EN) begin failures++; $display("FAIL tc_err act=%b exp=%b", bus.err, ERR_EN); end
    tick();
    ex = sb.pop_front();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_ocid !== ex.ocid) begin failures++; $display("FAIL tc_issue act=%b/%0d exp=1/%0d", bus.issue_valid, bus.issue_ocid, ex.ocid); end
    checks++; if (bus.issue_src1 !== ex.s1) begin failures++; $display("FAIL tc_src1 act=%h exp=%h", bus.issue_src1, ex.s1); end
  endtask

  task automatic test_drops();
    logic [DATA_W-1:0] x, y, w;
    x = rnd(); y = rnd(); w = rnd();
    do_reset();
    bus.issue_ready = 1'b1;
    alloc(3'd0, 1'b0, 1'b1, 6'd12); tick(); idle_inputs();
    resp(0, 4'b0000, x);
    tick(); idle_inputs();
    checks++; if (bus.err !== ERR_EN) begin failures++; $display("FAIL t5_err act=%b exp=%b", bus.err, ERR_EN); end
    checks++; if (bus.free_mask[0] !== 1'b0 || bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t5_wait act=%b/%b exp=0/0", bus.free_mask[0], bus.issue_valid); end
    alloc(3'd0, 1'b1, 1'b1, 6'd9); tick(); idle_inputs();
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t5_still_wait act=%b exp=0", bus.issue_valid); end
    resp(2, 4'b0001, y);
    sb.push_back('{ocid: 3'd0, tag: 6'd12, s1: '0, s2: y});
    tick(); idle_inputs();
    tick();
    ex = sb.pop_front();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== ex.tag) begin failures++; $display("FAIL t5_tag act=%b/%0d exp=1/%0d", bus.issue_valid, bus.issue_tag, ex.tag); end
    checks++; if (bus.issue_src1 !== ex.s1 || bus.issue_src2 !== ex.s2) begin failures++; $display("FAIL t5_src act=%h/%h exp=%h/%h", bus.issue_src1, bus.issue_src2, ex.s1, ex.s2); end
    alloc(3'd3, 1'b1, 1'b0, 6'd1);
    resp(1, 4'b0110, w);
    tick(); idle_inputs();
    tick();
    checks++; if (bus.free_mask[3] !== 1'b0 || bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t5_alloc_cycle act=%b/%b exp=0/0", bus.free_mask[3], bus.issue_valid); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    alloc(3'd1, 1'b1, 1'b0, 6'd3); tick();
    alloc(3'd2, 1'b0, 1'b1, 6'd4); tick();
    alloc(3'd3, 1'b1, 1'b1, 6'd6); tick();
    alloc(3'd5, 1'b0, 1'b0, 6'd7); tick();
    idle_inputs();
    resp(0, 4'b0011, rnd());
    tick(); idle_inputs();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_ocid !== 3'd5) begin failures++; $display("FAIL t6_pre act=%b/%0d exp=1/5", bus.issue_valid, bus.issue_ocid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t6_valid act=%b exp=0", bus.issue_valid); end
    checks++; if (bus.free_mask !== 8'hFF) begin failures++; $display("FAIL t6_free act=%h exp=ff", bus.free_mask); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL t6_err act=%b exp=0", bus.err); end
    checks++; if (bus.issue_ocid !== 3'd0 || bus.issue_tag !== 6'd0 || bus.issue_src1 !== '0 || bus.issue_src2 !== '0) begin
      failures++; $display("FAIL t6_fields act=%0d/%0d exp=0/0", bus.issue_ocid, bus.issue_tag);
    end
    resp(0, 4'b0010, rnd());
    tick(); idle_inputs();
    tick();
    checks++; if (bus.free_mask !== 8'hFF || bus.issue_valid !== 1'b0) begin failures++; $display("FAIL t6_stale act=%h/%b exp=ff/0", bus.free_mask, bus.issue_valid); end
  endtask

  initial begin
    idle_inputs();
    bus.issue_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_dual_land();
    test_collision();
    test_drops();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
